// File: rtl/mux5_rr_arbiter_if.sv
// Handshake bundle between the 5-way round-robin arbiter, its requesters, the shared mux and the consumer.
// master = arbiter side, slave = requesters/mux/consumer side.
interface mux5_rr_arbiter_if #(
  parameter int WORD_SIZE = 10,
  parameter int NUM_CH    = 5,
  parameter int SEL_W     = 3
);
  logic [NUM_CH-1:0]    req;
  logic [SEL_W-1:0]     mux_sel;
  logic [WORD_SIZE-1:0] mux_in;
  logic                 out_valid;
  logic                 out_ready;
  logic [WORD_SIZE-1:0] out_data;
  logic [NUM_CH-1:0]    gnt;
  logic                 busy;

  modport master (
    input  req, mux_in, out_ready,
    output mux_sel, out_valid, out_data, gnt, busy
  );

  modport slave (
    output req, mux_in, out_ready,
    input  mux_sel, out_valid, out_data, gnt, busy
  );
endinterface

// File: rtl/mux5_rr_arbiter.sv
// Round-robin sequencer sharing a 5-channel data mux: select, capture, present on valid/ready, pulse grant.
// Optional MUX5_ARB_CH0_PRIO_EN: channel 0 always wins, channels 1..4 rotate among themselves.
//
// state | meaning
// IDLE  | waiting for any req; arbitrates and drives mux_sel
// LOAD  | mux settled on winner; capture mux_in into out_data
// HOLD  | out_valid high, waiting for consumer out_ready
// GNT   | one-cycle grant pulse to the winner; no arbitration
module mux5_rr_arbiter #(
  parameter int WORD_SIZE = 10,
  parameter int NUM_CH    = 5,
  parameter int SEL_W     = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  mux5_rr_arbiter_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2,
    GNT  = 2'd3
  } state_t;

  state_t               state, state_nxt;
  logic [SEL_W-1:0]     mux_sel_q, mux_sel_nxt;
  logic [SEL_W-1:0]     last_ptr, last_ptr_nxt;
  logic [WORD_SIZE-1:0] out_data_q, out_data_nxt;
  logic                 out_valid_q, out_valid_nxt;
  logic [NUM_CH-1:0]    gnt_q, gnt_nxt;

  logic [SEL_W-1:0]     winner;
  logic                 win_found;
  logic [SEL_W:0]       scan_idx;

  localparam logic [NUM_CH-1:0] ONE_HOT0 = {{(NUM_CH-1){1'b0}}, 1'b1};

  always_comb begin
    winner    = '0;
    win_found = 1'b0;
    scan_idx  = '0;
`ifdef MUX5_ARB_CH0_PRIO_EN
    if (bus.req[0]) begin
      win_found = 1'b1;
    end else begin
      // ring of channels 1..4 only; last_ptr never holds 0 in this build
      for (int k = 1; k < NUM_CH; k++) begin
        scan_idx = {1'b0, last_ptr} + (SEL_W+1)'(k);
        if (scan_idx > (SEL_W+1)'(NUM_CH-1))
          scan_idx = scan_idx - (SEL_W+1)'(NUM_CH-1);
        if (!win_found && bus.req[scan_idx[SEL_W-1:0]]) begin
          winner    = scan_idx[SEL_W-1:0];
          win_found = 1'b1;
        end
      end
    end
`else
    for (int k = 1; k <= NUM_CH; k++) begin
      scan_idx = {1'b0, last_ptr} + (SEL_W+1)'(k);
      if (scan_idx >= (SEL_W+1)'(NUM_CH))
        scan_idx = scan_idx - (SEL_W+1)'(NUM_CH);
      if (!win_found && bus.req[scan_idx[SEL_W-1:0]]) begin
        winner    = scan_idx[SEL_W-1:0];
        win_found = 1'b1;
      end
    end
`endif
  end

  always_comb begin
    state_nxt     = state;
    mux_sel_nxt   = mux_sel_q;
    last_ptr_nxt  = last_ptr;
    out_data_nxt  = out_data_q;
    out_valid_nxt = out_valid_q;
    gnt_nxt       = '0;
    case (state)
      IDLE: begin
        if (win_found) begin
          mux_sel_nxt = winner;
          state_nxt   = LOAD;
        end
      end
      LOAD: begin
        out_data_nxt  = bus.mux_in;
        out_valid_nxt = 1'b1;
        state_nxt     = HOLD;
      end
      HOLD: begin
        if (out_valid_q && bus.out_ready) begin
          out_valid_nxt = 1'b0;
          gnt_nxt       = ONE_HOT0 << mux_sel_q;
`ifdef MUX5_ARB_CH0_PRIO_EN
          if (mux_sel_q != '0)
            last_ptr_nxt = mux_sel_q;
`else
          last_ptr_nxt = mux_sel_q;
`endif
          state_nxt = GNT;
        end
      end
      GNT: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      mux_sel_q   <= '0;
      last_ptr    <= SEL_W'(NUM_CH-1);
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      gnt_q       <= '0;
    end else begin
      state       <= state_nxt;
      mux_sel_q   <= mux_sel_nxt;
      last_ptr    <= last_ptr_nxt;
      out_data_q  <= out_data_nxt;
      out_valid_q <= out_valid_nxt;
      gnt_q       <= gnt_nxt;
    end
  end

  assign bus.mux_sel   = mux_sel_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.gnt       = gnt_q;
  assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_mux5_rr_arbiter.sv
// Directed bench for mux5_rr_arbiter: reset, single transfer, backpressure, rotation, ch0 priority, early drop.
module tb_mux5_rr_arbiter;
  localparam int WORD_SIZE = 10;
  localparam int NUM_CH    = 5;
  localparam int SEL_W     = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [WORD_SIZE-1:0] src [NUM_CH];
  int n_chk = 0;
  int n_bad = 0;

  mux5_rr_arbiter_if #(.WORD_SIZE(WORD_SIZE), .NUM_CH(NUM_CH), .SEL_W(SEL_W)) bus ();

  assign bus.mux_in = (bus.mux_sel < 3'd5) ? src[bus.mux_sel] : '0;

  mux5_rr_arbiter #(.WORD_SIZE(WORD_SIZE), .NUM_CH(NUM_CH), .SEL_W(SEL_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_gnt(input int budget, output int cycles, output logic timed_out,
                          output logic [WORD_SIZE-1:0] data_seen);
    cycles    = 0;
    timed_out = 1'b1;
    data_seen = '0;
    for (int i = 0; i < budget && timed_out; i++) begin
      tick();
      cycles++;
      if (bus.out_valid) data_seen = bus.out_data;
      if (bus.gnt != '0) timed_out = 1'b0;
    end
  endtask

  task automatic run_seq(input string name, input int n, input int exp_ch [6]);
    int                   cyc;
    logic                 to;
    logic [WORD_SIZE-1:0] dat;
    for (int i = 0; i < n; i++) begin
      wait_gnt(10, cyc, to, dat);
      chk({name, "_timeout"}, 32'(to), 32'd0);
      chk({name, "_gnt"}, 32'(bus.gnt), 32'(5'b00001 << exp_ch[i]));
      chk({name, "_data"}, 32'(dat), 32'(src[exp_ch[i]]));
      chk({name, "_spacing"}, 32'(cyc), (i == 0) ? 32'd3 : 32'd4);
    end
  endtask

  initial begin
    int rr_order [6];
    int pr_order [6];
    rr_order = '{0, 1, 2, 3, 4, 0};
`ifdef MUX5_ARB_CH0_PRIO_EN
    pr_order = '{0, 0, 0, 0, 0, 0};
`else
    pr_order = '{0, 3, 0, 3, 0, 0};
`endif
    src[0] = 10'h001;
    src[1] = 10'h0A2;
    src[2] = 10'h155;
    src[3] = 10'h2C3;
    src[4] = 10'h3FF;
    bus.req       = '0;
    bus.out_ready = 1'b1;

    // reset values
    #12;
    chk("rst_mux_sel", 32'(bus.mux_sel), 32'd0);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_data", 32'(bus.out_data), 32'd0);
    chk("rst_gnt", 32'(bus.gnt), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("idle_busy", 32'(bus.busy), 32'd0);

    // single transfer on ch2
    bus.req = 5'b00100;
    tick();
    chk("single_sel", 32'(bus.mux_sel), 32'd2);
    chk("single_busy", 32'(bus.busy), 32'd1);
    chk("single_valid_early", 32'(bus.out_valid), 32'd0);
    tick();
    chk("single_valid", 32'(bus.out_valid), 32'd1);
    chk("single_data", 32'(bus.out_data), 32'h155);
    tick();
    chk("single_gnt", 32'(bus.gnt), 32'(5'b00100));
    chk("single_valid_drop", 32'(bus.out_valid), 32'd0);
    bus.req = '0;
    tick();
    chk("single_idle", 32'(bus.busy), 32'd0);
    chk("single_gnt_end", 32'(bus.gnt), 32'd0);

    // backpressure: mux input changes while held, captured word must not
    bus.out_ready = 1'b0;
    bus.req = 5'b00100;
    tick();
    chk("bp_sel", 32'(bus.mux_sel), 32'd2);
    tick();
    chk("bp_valid", 32'(bus.out_valid), 32'd1);
    src[2] = 10'h2AA;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_hold_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_hold_data", 32'(bus.out_data), 32'h155);
      chk("bp_no_gnt", 32'(bus.gnt), 32'd0);
    end
    bus.out_ready = 1'b1;
    tick();
    chk("bp_gnt", 32'(bus.gnt), 32'(5'b00100));
    bus.req = '0;
    src[2] = 10'h155;
    tick();
    chk("bp_idle", 32'(bus.busy), 32'd0);

    // asynchronous reset mid-HOLD
    bus.out_ready = 1'b0;
    bus.req = 5'b01000;
    tick();
    chk("arst_pre_sel", 32'(bus.mux_sel), 32'd3);
    tick();
    chk("arst_pre_valid", 32'(bus.out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_gnt", 32'(bus.gnt), 32'd0);
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_sel", 32'(bus.mux_sel), 32'd0);
    chk("arst_data", 32'(bus.out_data), 32'd0);
    bus.req = '0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;

    // full round robin from reset pointer
    bus.req = 5'b11111;
    run_seq("rr", 6, rr_order);
    bus.req = '0;
    tick();
    chk("rr_idle", 32'(bus.busy), 32'd0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;

    // ch0 and ch3 competing
    bus.req = 5'b01001;
    run_seq("prio", 4, pr_order);
    bus.req = '0;
    tick();
    tick();

    // requester drops req during HOLD
    bus.out_ready = 1'b0;
    bus.req = 5'b00010;
    tick();
    chk("drop_sel", 32'(bus.mux_sel), 32'd1);
    tick();
    chk("drop_valid", 32'(bus.out_valid), 32'd1);
    bus.req = '0;
    tick();
    tick();
    chk("drop_hold", 32'(bus.out_valid), 32'd1);
    chk("drop_data", 32'(bus.out_data), 32'h0A2);
    bus.out_ready = 1'b1;
    tick();
    chk("drop_gnt", 32'(bus.gnt), 32'(5'b00010));
    tick();
    chk("drop_idle", 32'(bus.busy), 32'd0);
    chk("drop_gnt_end", 32'(bus.gnt), 32'd0);
    tick();
    chk("drop_stay_idle", 32'(bus.busy), 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
